// File: rtl/n_input_logic_gate_stream.sv
// ============================================================================
// Module     : n_input_logic_gate_stream
// Description: Registered N-input reduction gate (AND/OR/XOR and inverted
//              forms) that accumulates across multi-beat valid/ready packets.
//              Optional macro GATE_ONES_COUNT_EN adds the out_ones_o port.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module n_input_logic_gate_stream #(
  parameter int N      = 8,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N-1:0]      in_data_i,
  input  logic [2:0]        in_op_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_data_o,
  output logic [BEAT_W-1:0] out_beats_o,
`ifdef GATE_ONES_COUNT_EN
  output logic [BEAT_W+$clog2(N+1)-1:0] out_ones_o,
`endif
  output logic              out_err_o
);

  localparam int CNT_W  = $clog2(N + 1);
  localparam int ONES_W = BEAT_W + CNT_W;
  localparam logic [1:0] BASE_AND = 2'd0;
  localparam logic [1:0] BASE_OR  = 2'd1;
  localparam logic [1:0] BASE_XOR = 2'd2;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t              state_q;
  logic [2:0]          op_q;
  logic                acc_q;
  logic [BEAT_W-1:0]   beats_q;
  logic [ONES_W-1:0]   ones_q;
  logic                out_valid_q;
  logic                out_data_q;
  logic [BEAT_W-1:0]   out_beats_q;
  logic                out_err_q;
  logic [ONES_W-1:0]   out_ones_q;

  logic                w_accept;
  logic [2:0]          w_op;
  logic [1:0]          w_base;
  logic                w_inv;
  logic                w_err;
  logic                w_red;
  logic                acc_d;
  logic [BEAT_W-1:0]   beats_d;
  logic [CNT_W-1:0]    w_pop;
  logic [ONES_W:0]     w_ones_sum;
  logic [ONES_W-1:0]   ones_d;

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign w_accept   = in_valid_i & in_ready_o;

  always_comb begin
    // The op is only honoured on the first beat; later beats reuse the latched copy.
    w_op   = (state_q == S_IDLE) ? in_op_i : op_q;
    w_base = BASE_AND;
    w_inv  = 1'b0;
    w_err  = 1'b0;
    case (w_op)
      3'b000: w_base = BASE_AND;
      3'b001: w_base = BASE_OR;
      3'b010: w_base = BASE_XOR;
      3'b011: begin w_base = BASE_AND; w_inv = 1'b1; end
      3'b100: begin w_base = BASE_OR;  w_inv = 1'b1; end
      3'b101: begin w_base = BASE_XOR; w_inv = 1'b1; end
      default: begin w_base = BASE_AND; w_err = 1'b1; end
    endcase

    case (w_base)
      BASE_AND: w_red = &in_data_i;
      BASE_OR:  w_red = |in_data_i;
      default:  w_red = ^in_data_i;
    endcase

    if (state_q == S_IDLE) begin
      acc_d = w_red;
    end else begin
      case (w_base)
        BASE_AND: acc_d = acc_q & w_red;
        BASE_OR:  acc_d = acc_q | w_red;
        default:  acc_d = acc_q ^ w_red;
      endcase
    end

    if (state_q == S_IDLE)
      beats_d = BEAT_W'(1);
    else if (&beats_q)
      beats_d = beats_q;
    else
      beats_d = beats_q + BEAT_W'(1);

    w_pop = '0;
    for (int i = 0; i < N; i++)
      w_pop = w_pop + CNT_W'(in_data_i[i]);

    w_ones_sum = (state_q == S_IDLE) ? (ONES_W+1)'(w_pop)
                                     : {1'b0, ones_q} + (ONES_W+1)'(w_pop);
    ones_d = w_ones_sum[ONES_W] ? {ONES_W{1'b1}} : w_ones_sum[ONES_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      acc_q       <= 1'b0;
      beats_q     <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_beats_q <= '0;
      out_err_q   <= 1'b0;
      out_ones_q  <= '0;
    end else begin
      if (w_accept) begin
        if (in_last_i) begin
          state_q     <= S_IDLE;
          out_data_q  <= acc_d ^ w_inv;
          out_beats_q <= beats_d;
          out_err_q   <= w_err;
          out_ones_q  <= ones_d;
        end else begin
          state_q <= S_ACCUM;
          op_q    <= w_op;
          acc_q   <= acc_d;
          beats_q <= beats_d;
          ones_q  <= ones_d;
        end
      end

      if (w_accept && in_last_i)
        out_valid_q <= 1'b1;
      else if (out_ready_i)
        out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_beats_o = out_beats_q;
  assign out_err_o   = out_err_q;

`ifdef GATE_ONES_COUNT_EN
  assign out_ones_o = out_ones_q;
`else
  logic w_unused_ones;
  assign w_unused_ones = ^out_ones_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_n_input_logic_gate_stream.sv
// ============================================================================
// Module     : tb_n_input_logic_gate_stream
// Description: Directed self-checking bench for n_input_logic_gate_stream.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n_input_logic_gate_stream;

  localparam int N      = 8;
  localparam int BEAT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      in_data = '0;
  logic [2:0]        in_op = 3'b000;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_data;
  logic [BEAT_W-1:0] out_beats;
  logic              out_err;
`ifdef GATE_ONES_COUNT_EN
  logic [BEAT_W+$clog2(N+1)-1:0] out_ones;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  n_input_logic_gate_stream #(.N(N), .BEAT_W(BEAT_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_op_i     (in_op),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_beats_o (out_beats),
`ifdef GATE_ONES_COUNT_EN
    .out_ones_o  (out_ones),
`endif
    .out_err_o   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns 1 time unit after the edge that accepted it.
  task automatic send(input logic [N-1:0] d, input logic [2:0] op, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_last  = last;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    idle(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_beats", 32'(out_beats), 32'd0);
    check("rst_err",   32'(out_err),   32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    idle(2);

    // Single-beat AND of all ones
    send(8'hFF, 3'b000, 1'b1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'd1);
    check("t1_beats", 32'(out_beats), 32'd1);
    check("t1_err",   32'(out_err),   32'd0);
    idle(1);
    check("t1_drain", 32'(out_valid), 32'd0);

    // XOR over three beats with a bubble: 1 ^ 0 ^ 1
    send(8'h01, 3'b010, 1'b0);
    idle(2);
    send(8'h03, 3'b010, 1'b0);
    send(8'h07, 3'b010, 1'b1);
    check("t2_data",  32'(out_data),  32'd0);
    check("t2_beats", 32'(out_beats), 32'd3);
`ifdef GATE_ONES_COUNT_EN
    check("t2_ones",  32'(out_ones),  32'd6);
`endif

    // NAND: 1 & 0 = 0, inverted -> 1; mid-packet op change ignored
    send(8'hFF, 3'b011, 1'b0);
    send(8'hFE, 3'b001, 1'b1);
    check("t3_data",  32'(out_data),  32'd1);
    check("t3_beats", 32'(out_beats), 32'd2);
    check("t3_err",   32'(out_err),   32'd0);
    idle(1);

    // Backpressure: NOR of 0 = 1, held while consumer stalls
    out_ready = 1'b0;
    send(8'h00, 3'b100, 1'b1);
    check("t4_data", 32'(out_data), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_op    = 3'b101;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_ready", 32'(in_ready),  32'd0);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_data",  32'(out_data),  32'd1);
      check("t4_hold_beats", 32'(out_beats), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h01, 3'b101, 1'b1);
    check("t4_next_valid", 32'(out_valid), 32'd1);
    check("t4_next_data",  32'(out_data),  32'd0);
    check("t4_next_beats", 32'(out_beats), 32'd1);

    // Illegal op behaves as AND and flags error; next legal packet clears it
    send(8'hFF, 3'b111, 1'b1);
    check("t5_data", 32'(out_data), 32'd1);
    check("t5_err",  32'(out_err),  32'd1);
    send(8'h00, 3'b001, 1'b1);
    check("t5b_data", 32'(out_data), 32'd0);
    check("t5b_err",  32'(out_err),  32'd0);

    // Reset mid-packet: output regs loaded with nonzero values first
    send(8'hFF, 3'b111, 1'b1);
    send(8'hFF, 3'b000, 1'b0);
    send(8'hFF, 3'b000, 1'b0);
    check("t6_pre_err", 32'(out_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data",  32'(out_data),  32'd0);
    check("t6_beats", 32'(out_beats), 32'd0);
    check("t6_err",   32'(out_err),   32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send(8'h0F, 3'b001, 1'b1);
    check("t6_new_data",  32'(out_data),  32'd1);
    check("t6_new_beats", 32'(out_beats), 32'd1);

    // Beat counter saturation: 301 XOR beats of 8'h01 -> parity 1
    for (int b = 0; b < 300; b++)
      send(8'h01, 3'b010, 1'b0);
    send(8'h01, 3'b010, 1'b1);
    check("sat_data",  32'(out_data),  32'd1);
    check("sat_beats", 32'(out_beats), 32'd255);
`ifdef GATE_ONES_COUNT_EN
    check("sat_ones",  32'(out_ones),  32'd301);
`endif
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
